// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: edge-detects the baud square wave and shifts out
// start, LSB-first data, optional parity and stop bits from a one-entry holding register.
module uart_tx_serializer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_in,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned STOP_W = 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 baud_q;
  logic                 tick;
  logic                 load;
  logic                 accept;
  logic                 last_stop;
  logic [DATA_BITS-1:0] hold_data_q;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [STOP_W-1:0]    stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_d;
  logic                 frame_done_d;

  assign tick      = baud_in & ~baud_q;
  assign accept    = tx_valid & tx_ready;
  assign last_stop = (stop_cnt_q == LAST_STOP);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; load marks an unload of the holding register into the shifter
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = S_START;
          end
        end
        S_START: state_d = S_DATA;
        S_DATA: begin
          if (bit_cnt_q == LAST_BIT) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
        S_PARITY: state_d = S_STOP;
        S_STOP: begin
          if (last_stop) begin
            if (hold_full_q) begin
              load    = 1'b1;
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    tx_d         = tx;
    frame_done_d = 1'b0;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    parity_d     = parity_q;
    if (tick) begin
      case (state_q)
        S_START: begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
        S_DATA: begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            stop_cnt_d = '0;
            tx_d       = (PARITY_EN != 0) ? parity_q : 1'b1;
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
        S_PARITY: begin
          tx_d       = 1'b1;
          stop_cnt_d = '0;
        end
        S_STOP: begin
          if (last_stop) begin
            frame_done_d = 1'b1;
            tx_d         = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + STOP_W'(1);
          end
        end
        default: tx_d = 1'b1;
      endcase
    end
    // Loading a word overrides the line with the start bit
    if (load) begin
      shift_d  = hold_data_q;
      parity_d = (^hold_data_q) ^ 1'(PARITY_ODD);
      tx_d     = 1'b0;
    end
  end

  // Accept and unload are mutually exclusive since accept needs an empty register
  always_comb begin
    hold_full_d = hold_full_q;
    if (load)        hold_full_d = 1'b0;
    else if (accept) hold_full_d = 1'b1;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_q      <= 1'b0;
      hold_data_q <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= '0;
      parity_q    <= 1'b0;
      tx          <= 1'b1;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      tx_ready    <= 1'b1;
    end else begin
      baud_q      <= baud_in;
      if (accept) hold_data_q <= tx_data;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      parity_q    <= parity_d;
      tx          <= tx_d;
      busy        <= (state_d != S_IDLE);
      frame_done  <= frame_done_d;
      tx_ready    <= ~hold_full_d;
    end
  end

endmodule
